// File: rtl/cd_latch_ex_pkg.sv
// Package for the C/D latch exerciser.
//   state_t     - exerciser FSM states (9)
//   LFSR_SEED   - value loaded into the pattern LFSR at each start
//   LFSR_TAPS   - tap mask for the 8-bit Fibonacci LFSR (taps 8,6,5,4)
//   lfsr_next() - one LFSR shift step
package cd_latch_ex_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_SETUP,
    ST_OPEN,
    ST_CHECK_T,
    ST_CLOSE,
    ST_HOLD,
    ST_CHECK_H,
    ST_NEXT,
    ST_DONE
  } state_t;

  localparam logic [7:0] LFSR_SEED = 8'hA5;
  localparam logic [7:0] LFSR_TAPS = 8'hB8;  // bits 7,5,4,3 = taps 8,6,5,4

  function automatic logic [7:0] lfsr_next(input logic [7:0] cur);
    logic fb;
    fb = ^(cur & LFSR_TAPS);
    return {cur[6:0], fb};
  endfunction

endpackage

// File: rtl/cd_latch_ex_lfsr.sv
// 8-bit Fibonacci LFSR supplying the pattern bit when the exerciser is built
// with CD_LATCH_EX_LFSR_EN.
//   clk, rst_n  - clock, synchronous active-low reset (loads the seed)
//   load_i      - reload LFSR_SEED (takes priority over step_i)
//   step_i      - advance one position
//   lfsr_o      - current LFSR value
module cd_latch_ex_lfsr
  import cd_latch_ex_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load_i,
  input  logic       step_i,
  output logic [7:0] lfsr_o
);

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values of its inputs, independent of block ordering.
  always_ff @(posedge clk) begin
    if (!rst_n)      lfsr_o <= LFSR_SEED;
    else if (load_i) lfsr_o <= LFSR_SEED;
    else if (step_i) lfsr_o <= lfsr_next(lfsr_o);
  end

endmodule

// File: rtl/cd_latch_exerciser.sv
// Stimulus/checker for a C/D latch under test. On start_i it runs NUM_STEPS
// steps; each step opens the latch with D=b, checks transparency, closes it,
// flips D and checks that the latch held b. Reports done, pass, error count
// (saturating) and the step index of the first failure.
//   clk, rst_n        - clock, synchronous active-low reset
//   start_i           - start pulse, honoured only in IDLE
//   c_o, d_o          - registered C/D drive to the latch
//   q_i, qbar_i       - latch outputs, sampled directly in the check states
//   busy_o, done_o    - run in progress / one-cycle end-of-run pulse
//   pass_o            - no failures in last run, held until next start
//   err_cnt_o         - failing checks in this run, saturating
//   fail_idx_o        - step of first failure, valid when err_cnt_o != 0
// Build option: define CD_LATCH_EX_LFSR_EN to take the step bit from an
// 8-bit LFSR instead of the alternating 0,1,0,1 pattern.
module cd_latch_exerciser #(
  parameter int SETTLE    = 2,
  parameter int NUM_STEPS = 16,
  parameter int ERR_W     = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start_i,
  output logic                         c_o,
  output logic                         d_o,
  input  logic                         q_i,
  input  logic                         qbar_i,
  output logic                         busy_o,
  output logic                         done_o,
  output logic                         pass_o,
  output logic [ERR_W-1:0]             err_cnt_o,
  output logic [$clog2(NUM_STEPS)-1:0] fail_idx_o
);
  import cd_latch_ex_pkg::*;

  localparam int IDX_W = $clog2(NUM_STEPS);
  localparam int CNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [ERR_W-1:0]   err_q, err_d;
  logic [IDX_W-1:0]   fail_idx_q, fail_idx_d;
  logic               pass_q, pass_d;
  logic               chk, fail;
  logic               lfsr_load, lfsr_step;
  logic               b_q, b_d;   // step bit now / after this edge
  logic               c_d, d_d;

  // Step-bit source
`ifdef CD_LATCH_EX_LFSR_EN
  logic [7:0] lfsr_q, lfsr_nx;

  cd_latch_ex_lfsr u_lfsr (
    .clk    (clk),
    .rst_n  (rst_n),
    .load_i (lfsr_load),
    .step_i (lfsr_step),
    .lfsr_o (lfsr_q)
  );

  always_comb begin
    lfsr_nx = lfsr_q;
    if (lfsr_load)      lfsr_nx = LFSR_SEED;
    else if (lfsr_step) lfsr_nx = lfsr_next(lfsr_q);
  end

  assign b_q = lfsr_q[0];
  assign b_d = lfsr_nx[0];
`else
  logic unused_lfsr_ctrl;
  assign unused_lfsr_ctrl = lfsr_load ^ lfsr_step;
  assign b_q = idx_q[0];
  assign b_d = idx_d[0];
`endif

  // A check fails if either Q or Qbar disagrees with the current step bit.
  assign fail = chk && ((q_i != b_q) || (qbar_i == b_q));

  // Next-state and bookkeeping
  // NOTE: every signal gets a default before the case statement; a path that
  // leaves one unassigned would infer a latch.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    cnt_d      = cnt_q;
    err_d      = err_q;
    fail_idx_d = fail_idx_q;
    pass_d     = pass_q;
    chk        = 1'b0;
    lfsr_load  = 1'b0;
    lfsr_step  = 1'b0;

    unique case (state_q)
      ST_IDLE: if (start_i) begin
        state_d    = ST_SETUP;
        idx_d      = '0;
        err_d      = '0;
        fail_idx_d = '0;
        pass_d     = 1'b0;
        lfsr_load  = 1'b1;
      end
      ST_SETUP: begin
        state_d = ST_OPEN;
        cnt_d   = '0;
      end
      ST_OPEN: begin
        if (cnt_q == CNT_W'(SETTLE - 1)) state_d = ST_CHECK_T;
        else                             cnt_d   = cnt_q + 1'b1;
      end
      ST_CHECK_T: begin
        chk     = 1'b1;
        state_d = ST_CLOSE;
      end
      ST_CLOSE: begin
        state_d = ST_HOLD;
        cnt_d   = '0;
      end
      ST_HOLD: begin
        if (cnt_q == CNT_W'(SETTLE - 1)) state_d = ST_CHECK_H;
        else                             cnt_d   = cnt_q + 1'b1;
      end
      ST_CHECK_H: begin
        chk     = 1'b1;
        state_d = ST_NEXT;
      end
      ST_NEXT: begin
        lfsr_step = 1'b1;
        if (idx_q == IDX_W'(NUM_STEPS - 1)) begin
          state_d = ST_DONE;
          pass_d  = (err_q == '0);
        end else begin
          state_d = ST_SETUP;
          idx_d   = idx_q + 1'b1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    if (fail) begin
      if (err_q == '0)        fail_idx_d = idx_q;
      if (err_q != '1)        err_d      = err_q + 1'b1;
    end
  end

  // C/D drive for the state being entered, so the registered outputs line up
  // with the state register. D stays at b through the closing edge and
  // flips to ~b only once C is low.
  always_comb begin
    c_d = 1'b0;
    d_d = d_o;
    unique case (state_d)
      ST_SETUP, ST_CLOSE: d_d = b_d;
      ST_OPEN, ST_CHECK_T: begin
        c_d = 1'b1;
        d_d = b_d;
      end
      ST_HOLD, ST_CHECK_H: d_d = ~b_d;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      idx_q      <= '0;
      cnt_q      <= '0;
      err_q      <= '0;
      fail_idx_q <= '0;
      pass_q     <= 1'b0;
      c_o        <= 1'b0;
      d_o        <= 1'b0;
      busy_o     <= 1'b0;
      done_o     <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      cnt_q      <= cnt_d;
      err_q      <= err_d;
      fail_idx_q <= fail_idx_d;
      pass_q     <= pass_d;
      c_o        <= c_d;
      d_o        <= d_d;
      busy_o     <= (state_d != ST_IDLE);
      done_o     <= (state_d == ST_DONE);
    end
  end

  assign pass_o     = pass_q;
  assign err_cnt_o  = err_q;
  assign fail_idx_o = fail_idx_q;

endmodule

// File: tb/tb_cd_latch_exerciser.sv
// Directed bench for cd_latch_exerciser (default build: alternating step bit).
// A behavioural latch model sits on the C/D outputs; mode selects an ideal
// latch, Q stuck 0 / Qbar stuck 1, or a latch that ignores C. A second
// instance with ERR_W=3 shares the same latch outputs to exercise saturation.
module tb_cd_latch_exerciser;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start_i;
  logic       c_o, d_o, busy_o, done_o, pass_o;
  logic [7:0] err_cnt_o;
  logic [3:0] fail_idx_o;
  logic       c3, d3, busy3, done3, pass3;
  logic [2:0] err3;
  logic [3:0] fidx3;
  logic       q_i, qbar_i;
  logic       lat_q;
  int         mode;   // 0 ideal, 1 stuck, 2 transparent-only

  int checks = 0;
  int errors = 0;

  int         wave_cyc[4] = '{2, 6, 11, 15};
  logic [1:0] wave_exp[4] = '{2'b10, 2'b01, 2'b11, 2'b00};

  always #5 clk = ~clk;

  always_latch if (c_o) lat_q = d_o;

  assign q_i    = (mode == 1) ? 1'b0 : (mode == 2) ? d_o : lat_q;
  assign qbar_i = (mode == 1) ? 1'b1 : ~q_i;

  cd_latch_exerciser dut (
    .clk(clk), .rst_n(rst_n), .start_i(start_i), .c_o(c_o), .d_o(d_o),
    .q_i(q_i), .qbar_i(qbar_i), .busy_o(busy_o), .done_o(done_o),
    .pass_o(pass_o), .err_cnt_o(err_cnt_o), .fail_idx_o(fail_idx_o)
  );

  cd_latch_exerciser #(.ERR_W(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .start_i(start_i), .c_o(c3), .d_o(d3),
    .q_i(q_i), .qbar_i(qbar_i), .busy_o(busy3), .done_o(done3),
    .pass_o(pass3), .err_cnt_o(err3), .fail_idx_o(fidx3)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Called at a negedge. Pulses start, then walks the run one cycle at a
  // time (cycle 1 = first cycle after the start edge). Returns the cycle in
  // which done_o was seen, or -1 if the run was aborted / never finished.
  task automatic run_seq(input string tag, input int extra_start, input int rst_at,
                         input bit wave, output int done_at);
    bit stop;
    done_at = -1;
    stop    = 1'b0;
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    for (int n = 1; n <= 400 && !stop; n++) begin
      if (n == 1) check({tag, ".busy_start"}, busy_o, 1);
      if (wave)
        for (int k = 0; k < 4; k++)
          if (n == wave_cyc[k]) check($sformatf("%s.cd_cyc%0d", tag, n), {c_o, d_o}, wave_exp[k]);
      if (done_o) begin
        done_at = n;
        stop    = 1'b1;
      end else if (n == rst_at) begin
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        stop  = 1'b1;
      end else begin
        start_i = (n == extra_start);
        @(negedge clk);
        start_i = 1'b0;
      end
    end
  endtask

  int done_at;
  int dones;

  initial begin
    mode    = 0;
    rst_n   = 1'b0;
    start_i = 1'b0;
    repeat (3) @(negedge clk);

    // Reset state
    check("rst.c",     c_o, 0);
    check("rst.d",     d_o, 0);
    check("rst.busy",  busy_o, 0);
    check("rst.done",  done_o, 0);
    check("rst.pass",  pass_o, 0);
    check("rst.err",   err_cnt_o, 0);
    check("rst.fidx",  fail_idx_o, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Ideal latch, with C/D waveform spot checks
    run_seq("ideal", 0, 0, 1'b1, done_at);
    check("ideal.len",  done_at, 145);
    check("ideal.err",  err_cnt_o, 0);
    check("ideal.pass", pass_o, 1);
    @(negedge clk);
    check("ideal.busy_end", busy_o, 0);
    check("ideal.done_end", done_o, 0);
    check("ideal.pass_held", pass_o, 1);

    // Q stuck 0 / Qbar stuck 1: both checks fail on every odd step
    mode = 1;
    run_seq("stuck", 0, 0, 1'b0, done_at);
    check("stuck.len",   done_at, 145);
    check("stuck.err",   err_cnt_o, 16);
    check("stuck.fidx",  fail_idx_o, 1);
    check("stuck.pass",  pass_o, 0);
    check("sat.err",     err3, 7);
    check("sat.fidx",    fidx3, 1);
    check("sat.pass",    pass3, 0);
    @(negedge clk);

    // Latch that ignores C: every hold check fails
    mode = 2;
    run_seq("transp", 0, 0, 1'b0, done_at);
    check("transp.len",  done_at, 145);
    check("transp.err",  err_cnt_o, 16);
    check("transp.fidx", fail_idx_o, 0);
    check("transp.pass", pass_o, 0);
    @(negedge clk);

    // start_i mid-run is ignored
    mode = 0;
    run_seq("restart", 20, 0, 1'b0, done_at);
    check("restart.len",  done_at, 145);
    check("restart.err",  err_cnt_o, 0);
    check("restart.pass", pass_o, 1);
    @(negedge clk);

    // Reset mid-run (stuck model, so errors have accumulated by cycle 30)
    mode = 1;
    run_seq("abort", 0, 30, 1'b0, done_at);
    check("abort.no_done_in_run", done_at, -1);
    check("abort.c",    c_o, 0);
    check("abort.d",    d_o, 0);
    check("abort.busy", busy_o, 0);
    check("abort.done", done_o, 0);
    check("abort.pass", pass_o, 0);
    check("abort.err",  err_cnt_o, 0);
    check("abort.fidx", fail_idx_o, 0);
    dones = 0;
    for (int n = 0; n < 200; n++) begin
      if (done_o) dones++;
      @(negedge clk);
    end
    check("abort.late_done", dones, 0);

    mode = 0;
    run_seq("after", 0, 0, 1'b0, done_at);
    check("after.len",  done_at, 145);
    check("after.err",  err_cnt_o, 0);
    check("after.pass", pass_o, 1);
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
